// File: rtl/render_pkg.sv
// Shared colours, board geometry defaults and the per-axis locator result type.
// With RENDER_GRID_EN defined, the renderer draws cell grid lines in C_GRID.
package render_pkg;

  localparam logic [11:0] C_WHITE   = 12'hFFF;
  localparam logic [11:0] C_BLUE    = 12'h00F;
  localparam logic [11:0] C_GREEN   = 12'h0F0;
  localparam logic [11:0] C_RED     = 12'hF00;
  localparam logic [11:0] C_CYAN    = 12'h0FF;
  localparam logic [11:0] C_YELLOW  = 12'hFF0;
  localparam logic [11:0] C_MAGENTA = 12'hF0F;
  localparam logic [11:0] C_BLACK   = 12'h000;
  localparam logic [11:0] C_GRID    = 12'h888;
  localparam logic [11:0] C_CURSOR  = 12'h000;

  localparam int DEF_ORIGIN_X   = 120;
  localparam int DEF_ORIGIN_Y   = 40;
  localparam int DEF_CELL       = 50;
  localparam int DEF_CURSOR_W   = 3;
  localparam int DEF_BLINK_LOG2 = 5;

  typedef struct packed {
    logic       in_range;
    logic [2:0] idx;
    logic [5:0] off;
  } loc_t;

  function automatic logic [11:0] cell_colour(input logic [2:0] code);
    case (code)
      3'd0:    cell_colour = C_WHITE;
      3'd1:    cell_colour = C_BLUE;
      3'd2:    cell_colour = C_GREEN;
      3'd3:    cell_colour = C_RED;
      3'd4:    cell_colour = C_CYAN;
      3'd5:    cell_colour = C_YELLOW;
      3'd6:    cell_colour = C_MAGENTA;
      default: cell_colour = C_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/cell_locator.sv
// Maps one pixel coordinate to {in_range, cell index, in-cell offset}
// using a compare chain against ORIGIN+k*CELL instead of a divider.
module cell_locator
  import render_pkg::*;
#(
  parameter int W      = 10,
  parameter int ORIGIN = DEF_ORIGIN_X,
  parameter int CELL   = DEF_CELL
) (
  input  logic [W-1:0] coord,
  output loc_t         loc
);

  logic [7:0]  ge;
  logic [2:0]  idx;
  logic [15:0] base;

  for (genvar gi = 0; gi < 8; gi++) begin : g_cmp
    assign ge[gi] = (int'(coord) >= ORIGIN + gi * CELL);
  end

  // The chain is monotonic, so the highest set compare is the cell index.
  always_comb begin
    idx = 3'd0;
    for (int k = 1; k < 8; k++)
      if (ge[k]) idx = 3'(k);
  end

  assign base         = 16'(ORIGIN) + 16'(idx) * 16'(CELL);
  assign loc.idx      = idx;
  assign loc.off      = 6'(16'(coord) - base);
  assign loc.in_range = ge[0] && (int'(coord) < ORIGIN + 8 * CELL);

endmodule

// File: rtl/board_renderer.sv
// Chess board pixel generator: per-frame board/cursor snapshot, 2-cycle pipeline.
// Optional grid lines are enabled by defining RENDER_GRID_EN.
module board_renderer
  import render_pkg::*;
#(
  parameter int ORIGIN_X   = DEF_ORIGIN_X,
  parameter int ORIGIN_Y   = DEF_ORIGIN_Y,
  parameter int CELL       = DEF_CELL,
  parameter int CURSOR_W   = DEF_CURSOR_W,
  parameter int BLINK_LOG2 = DEF_BLINK_LOG2
) (
  input  logic         clk,
  input  logic         clrn,
  input  logic [191:0] board_in,
  input  logic         board_valid,
  input  logic [3:0]   cur_x,
  input  logic [3:0]   cur_y,
  input  logic [9:0]   col_addr,
  input  logic [8:0]   row_addr,
  output logic [11:0]  pix_out,
  output logic         frame_tick
);

  logic [191:0]          board_shadow;
  logic [3:0]            cur_x_shadow;
  logic [3:0]            cur_y_shadow;
  logic [BLINK_LOG2-1:0] blink_cnt;
  logic                  snap;

  loc_t       col_loc;
  loc_t       row_loc;
  logic       in_board_s1;
  logic [2:0] r_s1;
  logic [2:0] c_s1;
  logic [5:0] ox_s1;
  logic [5:0] oy_s1;

  logic [2:0]  cells [64];
  logic        border;
  logic        cursor_hit;
  logic [11:0] pix_next;

  assign snap = (row_addr == 9'd480) && (col_addr == 10'd0);

  cell_locator #(.W(10), .ORIGIN(ORIGIN_X), .CELL(CELL)) u_col_loc (
    .coord (col_addr),
    .loc   (col_loc)
  );

  cell_locator #(.W(9), .ORIGIN(ORIGIN_Y), .CELL(CELL)) u_row_loc (
    .coord (row_addr),
    .loc   (row_loc)
  );

  // Snapshot registers: rendering never looks at the live board or cursor.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      board_shadow <= '0;
      cur_x_shadow <= 4'd8;
      cur_y_shadow <= 4'd8;
      blink_cnt    <= '0;
      frame_tick   <= 1'b0;
    end else begin
      frame_tick <= snap;
      if (snap) begin
        cur_x_shadow <= cur_x;
        cur_y_shadow <= cur_y;
        blink_cnt    <= blink_cnt + 1'b1;
        if (board_valid) board_shadow <= board_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      in_board_s1 <= 1'b0;
      r_s1        <= '0;
      c_s1        <= '0;
      ox_s1       <= '0;
      oy_s1       <= '0;
    end else begin
      in_board_s1 <= col_loc.in_range && row_loc.in_range;
      r_s1        <= row_loc.idx;
      c_s1        <= col_loc.idx;
      ox_s1       <= col_loc.off;
      oy_s1       <= row_loc.off;
    end
  end

  for (genvar gi = 0; gi < 64; gi++) begin : g_cells
    assign cells[gi] = board_shadow[gi*3 +: 3];
  end

  always_comb begin
    border = (ox_s1 < 6'(CURSOR_W)) || (oy_s1 < 6'(CURSOR_W)) ||
             (ox_s1 >= 6'(CELL - CURSOR_W)) || (oy_s1 >= 6'(CELL - CURSOR_W));
    cursor_hit = border && !blink_cnt[BLINK_LOG2-1] &&
                 (cur_x_shadow == {1'b0, c_s1}) && (cur_y_shadow == {1'b0, r_s1});
    pix_next = cell_colour(cells[{r_s1, c_s1}]);
`ifdef RENDER_GRID_EN
    if (ox_s1 == 6'd0 || oy_s1 == 6'd0) pix_next = C_GRID;
`else
`endif
    if (cursor_hit)   pix_next = C_CURSOR;
    if (!in_board_s1) pix_next = C_WHITE;
  end

  always_ff @(posedge clk) begin
    if (!clrn) pix_out <= C_WHITE;
    else       pix_out <= pix_next;
  end

endmodule

// File: tb/tb_board_renderer.sv
// Self-checking bench for board_renderer: directed steps followed by random
// addresses/boards/cursors compared against an arithmetic reference model.
module tb_board_renderer;

  logic         clk = 1'b0;
  logic         clrn;
  logic [191:0] board_in;
  logic         board_valid;
  logic [3:0]   cur_x;
  logic [3:0]   cur_y;
  logic [9:0]   col_addr;
  logic [8:0]   row_addr;
  logic [11:0]  pix_out;
  logic         frame_tick;

  board_renderer dut (
    .clk         (clk),
    .clrn        (clrn),
    .board_in    (board_in),
    .board_valid (board_valid),
    .cur_x       (cur_x),
    .cur_y       (cur_y),
    .col_addr    (col_addr),
    .row_addr    (row_addr),
    .pix_out     (pix_out),
    .frame_tick  (frame_tick)
  );

  always #5 clk = ~clk;

  localparam logic [11:0] CMAP [8] = '{12'hFFF, 12'h00F, 12'h0F0, 12'hF00,
                                       12'h0FF, 12'hFF0, 12'hF0F, 12'h000};

  int m_board [64];
  int m_cx, m_cy, m_blink;
  logic [11:0] pipe0, pipe1;
  logic tick_exp;
  int n_assert = 0;
  int n_fail   = 0;

  function automatic logic [11:0] ref_pix(input int row, input int col);
    int r, c, ox, oy;
    logic [11:0] p;
    if (row < 40 || row >= 440 || col < 120 || col >= 520) return 12'hFFF;
    r  = (row - 40) / 50;
    c  = (col - 120) / 50;
    oy = (row - 40) % 50;
    ox = (col - 120) % 50;
    p  = CMAP[m_board[r*8 + c]];
`ifdef RENDER_GRID_EN
    if (ox == 0 || oy == 0) p = 12'h888;
`else
`endif
    if (r == m_cy && c == m_cx && ((m_blink / 16) % 2) == 0 &&
        (ox < 3 || oy < 3 || ox >= 47 || oy >= 47)) p = 12'h000;
    return p;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_board[i] = 0;
    m_cx = 8; m_cy = 8; m_blink = 0;
  endtask

  // One clock: apply an address, advance the model, compare both outputs.
  task automatic step(input int row, input int col, input logic rst_n);
    row_addr = row[8:0];
    col_addr = col[9:0];
    clrn     = rst_n;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      pipe1 = 12'hFFF; pipe0 = 12'hFFF; tick_exp = 1'b0;
      model_reset();
    end else begin
      pipe1    = pipe0;
      pipe0    = ref_pix(row, col);
      tick_exp = (row == 480 && col == 0);
      if (tick_exp) begin
        m_cx = int'(cur_x); m_cy = int'(cur_y);
        m_blink = (m_blink + 1) % 32;
        if (board_valid)
          for (int i = 0; i < 64; i++) m_board[i] = int'(board_in[i*3 +: 3]);
      end
    end
    n_assert++;
    assert (pix_out === pipe1) else begin
      n_fail++;
      $error("FAIL pix_out addr=(%0d,%0d) observed=%h expected=%h", row, col, pix_out, pipe1);
    end
    n_assert++;
    assert (frame_tick === tick_exp) else begin
      n_fail++;
      $error("FAIL frame_tick addr=(%0d,%0d) observed=%b expected=%b", row, col, frame_tick, tick_exp);
    end
    $display("step rst_n=%b addr=(%0d,%0d) pix_out=%h tick=%b", rst_n, row, col, pix_out, frame_tick);
  endtask

  task automatic fill_board(input int code);
    for (int i = 0; i < 64; i++) board_in[i*3 +: 3] = code[2:0];
  endtask

  initial begin
    int sel, row, col, cx, cy, v;
    int offs [6] = '{0, 1, 2, 47, 48, 49};
    model_reset();
    pipe0 = 12'hFFF; pipe1 = 12'hFFF; tick_exp = 1'b0;
    board_in = '0; board_valid = 1'b0; cur_x = 4'd9; cur_y = 4'd9;
    row_addr = '0; col_addr = '0; clrn = 1'b0;

    // Reset state
    step(0, 0, 1'b0);
    step(0, 0, 1'b0);

    // All cells colour 1, captured at row 480
    fill_board(1); board_valid = 1'b1;
    step(300, 300, 1'b1);
    step(480, 0, 1'b1);
    step(100, 200, 1'b1);
    step(0, 0, 1'b1);
    step(0, 0, 1'b1);

    // Single magenta cell (2,5), plus a pixel just above the board
    fill_board(0); board_in[(8*2+5)*3 +: 3] = 3'd6;
    step(480, 0, 1'b1);
    step(40 + 2*50 + 10, 120 + 5*50 + 10, 1'b1);
    step(39, 300, 1'b1);
    step(0, 0, 1'b1);
    step(0, 0, 1'b1);

    // Mid-frame board change stays invisible until the next snapshot
    fill_board(3);
    step(200, 130, 1'b1);
    step(300, 400, 1'b1);
    step(479, 500, 1'b1);
    step(480, 0, 1'b1);
    step(200, 130, 1'b1);
    step(0, 0, 1'b1);
    step(0, 0, 1'b1);

    // Cursor at (3,3), offset (1,1), then board_valid=0 at a snapshot
    cur_x = 4'd3; cur_y = 4'd3; board_valid = 1'b0; fill_board(5);
    step(480, 0, 1'b1);
    step(40 + 150 + 1, 120 + 150 + 1, 1'b1);
    step(40 + 150 + 25, 120 + 150 + 25, 1'b1);
    step(0, 0, 1'b1);
    step(0, 0, 1'b1);

    // Randomized phase
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 9) == 0)
        for (int i = 0; i < 64; i++) board_in[i*3 +: 3] = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 4) == 0) board_valid = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 7) == 0) begin
        v = $urandom_range(0, 9); cur_x = 4'(v);
        v = $urandom_range(0, 9); cur_y = 4'(v);
      end
      sel = $urandom_range(0, 99);
      if (sel < 8) begin
        row = 480; col = 0;
      end else if (sel < 40) begin
        cx = (m_cx < 8) ? m_cx : $urandom_range(0, 7);
        cy = (m_cy < 8) ? m_cy : $urandom_range(0, 7);
        row = 40 + cy*50 + (($urandom_range(0, 1) == 0) ? offs[$urandom_range(0, 5)] : $urandom_range(0, 49));
        col = 120 + cx*50 + (($urandom_range(0, 1) == 0) ? offs[$urandom_range(0, 5)] : $urandom_range(0, 49));
      end else if (sel < 88) begin
        row = $urandom_range(40, 439); col = $urandom_range(120, 519);
      end else begin
        row = $urandom_range(0, 511); col = $urandom_range(0, 1023);
      end
      step(row, col, (n == 1500) ? 1'b0 : 1'b1);
    end

    // Reset at row 250, then grid pixel in cell (0,1) after a fresh snapshot
    step(250, 300, 1'b0);
    step(250, 301, 1'b1);
    step(300, 300, 1'b1);
    fill_board(2); board_valid = 1'b1; cur_x = 4'd9;
    step(480, 0, 1'b1);
    step(40 + 10, 120 + 50, 1'b1);
    step(40, 120 + 60, 1'b1);
    step(0, 0, 1'b1);
    step(0, 0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
